ag32gbd_frame_scanner: RTL
==========================

# ag32gbd_frame_scanner

- Walks the full 128x112 Game Boy Camera frame in raster order.
- Drives the per-pixel sampler through its SampleStart/SampleDone handshake and collects each 2-bit SampledValue.
- Packs eight pixels per tile row into Game Boy 2bpp tile format and writes them into the frame buffer BRAM.
- Sits directly downstream of the sampler (consumes SampledValue) and upstream of the frame buffer read-out logic.

## Interface
- SAMPLE_TIMEOUT, default 4096: sys_clock cycles to wait for SampleDone before the pixel is forced to 2'b00.
- sys_clock  in  1  system clock (100 MHz); the only clock. All outputs are registered.
- sys_resetn  in  1  asynchronous, active-low reset.
- FrameStart  in  1  one-cycle pulse that starts a frame scan; ignored while FrameBusy=1.
- FrameAbort  in  1  level; when high, stops the scan and returns to IDLE.
- FrameBusy  out  1  high from the cycle after an accepted FrameStart until FrameDone or abort.
- FrameDone  out  1  one-cycle pulse when the last tile-row bytes have been written.
- SampleTimeoutErr  out  1  sticky; set on any timeout, cleared by an accepted FrameStart.
- SampleStart  out  1  request to the sampler; the sampler acts on its rising edge.
- PixelX  out  7  current pixel column, 0..127.
- PixelY  out  7  current pixel row, 0..111.
- SampleDone  in  1  from the sampler; high for 7 cycles after each sample.
- SampledValue  in  2  pixel value; valid while SampleDone=1.
- FbWriteEn  out  1  frame buffer write strobe, one cycle per byte.
- FbWriteAddr  out  12  frame buffer byte address.
- FbWriteData  out  8  frame buffer byte data.

## Operation
- States: IDLE, REQ, WAIT_DONE, WAIT_LOW, WR_LO, WR_HI, NEXT.
- IDLE:
  - On FrameStart, clear PixelX, PixelY, SampleTimeoutErr and both plane shift registers.
  - Set FrameBusy and go to REQ.
- REQ: assert SampleStart, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - Hold SampleStart high.
  - On the rising edge of SampleDone (SampleDone=1 and its registered copy =0), capture SampledValue:
    - shift bit0 into plane LO and bit1 into plane HI, MSB first, so the leftmost pixel ends up in bit 7;
    - drop SampleStart and go to WAIT_LOW.
  - If the counter reaches SAMPLE_TIMEOUT-1 first:
    - shift in 2'b00, set SampleTimeoutErr, drop SampleStart, go to WAIT_LOW.
- WAIT_LOW:
  - Stay until SampleDone=0 and SampleStart has been low for at least 2 cycles.
  - Then go to WR_LO if PixelX[2:0]==7, else NEXT.
- Tile addressing:
  - tile = PixelY[6:3]*16 + PixelX[6:3], range 0..223.
  - Base address = tile*16 + PixelY[2:0]*2.
- WR_LO: FbWriteEn=1, address = base, data = plane LO.
- WR_HI: FbWriteEn=1, address = base+1, data = plane HI. Then go to NEXT.
- NEXT:
  - If PixelX=127 and PixelY=111: pulse FrameDone, clear FrameBusy, go to IDLE.
  - Else if PixelX=127: PixelX=0 and PixelY increments.
  - Else PixelX increments.
  - In the last two cases, go to REQ.
- Width rules:
  - All address arithmetic is 12-bit unsigned.
  - The highest address in a frame is 3583; addresses 3584..4095 are never written.
- FrameAbort=1 in any non-IDLE state:
  - Next state is IDLE; SampleStart, FbWriteEn and FrameBusy drop to 0.
  - No FrameDone; a partial tile row is discarded.
  - Abort takes priority over a write in the same cycle (no write is issued).
- FrameStart and FrameAbort high in the same cycle in IDLE: abort wins and the start is ignored.
- Reset mid-frame: all state is cleared immediately; no write completes after reset asserts.

## Timing
- Reset values:
  - SampleStart, FbWriteEn, FrameBusy, FrameDone, SampleTimeoutErr: 0.
  - PixelX, PixelY, FbWriteAddr, FbWriteData: 0.
  - State = IDLE.
- FrameStart accepted in cycle N: FrameBusy=1 and state REQ at N+1, SampleStart=1 at N+2.
- PixelX and PixelY are stable from REQ until NEXT, so the sampler sees a constant coordinate for the whole sample.
- Capture happens 1 cycle after SampleDone rises; SampleStart is low the following cycle.
- WR_LO and WR_HI are back-to-back cycles; the frame buffer accepts one write per cycle with no backpressure.
- Each frame issues exactly 3584 writes and 14336 SampleStart rising edges (absent timeouts and aborts).

## Test plan
- Sampler model returning SampledValue=2'b11 for every pixel with 10-cycle latency, then FrameStart:
  - 3584 writes, all data 8'hFF, addresses 0..3583 each written exactly once;
  - single FrameDone; FrameBusy then low.
- Sampler model returning value = PixelX[1:0]:
  - write at address 0 = 8'h55 (LO plane), address 1 = 8'h33 (HI plane);
  - pixel (8,0) maps to address 16; pixel (0,8) maps to address 256; pixel (127,111) maps to address 3582/3583.
- Sampler never asserts SampleDone for pixel (3,0):
  - after SAMPLE_TIMEOUT cycles SampleTimeoutErr=1 and the pixel is recorded as 00, so address 0 = 8'hEF and address 1 = 8'hEF when all other pixels are 11;
  - the scan continues to FrameDone.
- FrameAbort pulsed while waiting at pixel (5,2):
  - no further writes, SampleStart=0, FrameBusy=0, no FrameDone;
  - a new FrameStart restarts at (0,0) and clears SampleTimeoutErr.
- FrameStart pulsed again mid-frame: ignored; write count and final FrameDone unchanged.
- sys_resetn asserted during WR_LO: FbWriteEn drops to 0 with no WR_HI, and all outputs return to their reset values.

Source files
------------

// File: rtl/ag32gbd_frame_scanner.sv
// Raster-scans the 128x112 camera frame through the pixel sampler handshake and
// packs each tile row of eight pixels into two 2bpp bytes for the frame buffer.
module ag32gbd_frame_scanner #(
   parameter int unsigned SAMPLE_TIMEOUT = 4096
) (
   input  logic        sys_clock,
   input  logic        sys_resetn,
   input  logic        FrameStart,
   input  logic        FrameAbort,
   output logic        FrameBusy,
   output logic        FrameDone,
   output logic        SampleTimeoutErr,
   output logic        SampleStart,
   output logic [6:0]  PixelX,
   output logic [6:0]  PixelY,
   input  logic        SampleDone,
   input  logic [1:0]  SampledValue,
   output logic        FbWriteEn,
   output logic [11:0] FbWriteAddr,
   output logic [7:0]  FbWriteData
);

   localparam int unsigned TimerW = (SAMPLE_TIMEOUT > 1) ? $clog2(SAMPLE_TIMEOUT) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StReq, StWaitDone, StWaitLow, StWrLo, StWrHi, StNext
   } scanState_t;

   scanState_t        stateQ, stateD;
   logic [6:0]        pixelXQ, pixelXD, pixelYQ, pixelYD;
   logic [7:0]        planeLoQ, planeLoD, planeHiQ, planeHiD;
   logic [TimerW-1:0] timerQ, timerD;
   logic              doneQ, ssLowQ;
   logic              busyQ, busyD, frameDoneQ, frameDoneD, errQ, errD;
   logic              sampleStartQ, sampleStartD, fbWeQ, fbWeD;
   logic [11:0]       fbAddrQ, fbAddrD;
   logic [7:0]        fbDataQ, fbDataD;
   logic              doneRise;
   logic [11:0]       baseAddr;

   assign doneRise = SampleDone & ~doneQ;
   // tile*16 + row*2, with tile = Y[6:3]*16 + X[6:3], is a pure bit concatenation
   assign baseAddr = {pixelYQ[6:3], pixelXQ[6:3], pixelYQ[2:0], 1'b0};

   always_comb begin
      stateD       = stateQ;
      pixelXD      = pixelXQ;
      pixelYD      = pixelYQ;
      planeLoD     = planeLoQ;
      planeHiD     = planeHiQ;
      timerD       = timerQ;
      busyD        = busyQ;
      frameDoneD   = 1'b0;
      errD         = errQ;
      sampleStartD = 1'b0;
      fbWeD        = 1'b0;
      fbAddrD      = fbAddrQ;
      fbDataD      = fbDataQ;

      unique case (stateQ)
         StIdle: begin
            if (FrameStart && !FrameAbort) begin
               pixelXD  = '0;
               pixelYD  = '0;
               errD     = 1'b0;
               planeLoD = '0;
               planeHiD = '0;
               busyD    = 1'b1;
               stateD   = StReq;
            end
         end
         StReq: begin
            sampleStartD = 1'b1;
            timerD       = '0;
            stateD       = StWaitDone;
         end
         StWaitDone: begin
            sampleStartD = 1'b1;
            timerD       = timerQ + 1'b1;
            if (doneRise) begin
               planeLoD     = {planeLoQ[6:0], SampledValue[0]};
               planeHiD     = {planeHiQ[6:0], SampledValue[1]};
               sampleStartD = 1'b0;
               stateD       = StWaitLow;
            end else if (timerQ == TimerLast) begin
               planeLoD     = {planeLoQ[6:0], 1'b0};
               planeHiD     = {planeHiQ[6:0], 1'b0};
               errD         = 1'b1;
               sampleStartD = 1'b0;
               stateD       = StWaitLow;
            end
         end
         StWaitLow: begin
            // ssLowQ plus the current low SampleStart gives two low cycles
            if (!SampleDone && !sampleStartQ && ssLowQ) begin
               stateD = (pixelXQ[2:0] == 3'd7) ? StWrLo : StNext;
            end
         end
         StWrLo: begin
            fbWeD   = 1'b1;
            fbAddrD = baseAddr;
            fbDataD = planeLoQ;
            stateD  = StWrHi;
         end
         StWrHi: begin
            fbWeD   = 1'b1;
            fbAddrD = {baseAddr[11:1], 1'b1};
            fbDataD = planeHiQ;
            stateD  = StNext;
         end
         StNext: begin
            if (pixelXQ == 7'd127 && pixelYQ == 7'd111) begin
               frameDoneD = 1'b1;
               busyD      = 1'b0;
               stateD     = StIdle;
            end else begin
               if (pixelXQ == 7'd127) begin
                  pixelXD = '0;
                  pixelYD = pixelYQ + 7'd1;
               end else begin
                  pixelXD = pixelXQ + 7'd1;
               end
               stateD = StReq;
            end
         end
         default: stateD = StIdle;
      endcase

      if (FrameAbort && stateQ != StIdle) begin
         stateD       = StIdle;
         sampleStartD = 1'b0;
         fbWeD        = 1'b0;
         busyD        = 1'b0;
         frameDoneD   = 1'b0;
      end
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         stateQ       <= StIdle;
         pixelXQ      <= '0;
         pixelYQ      <= '0;
         planeLoQ     <= '0;
         planeHiQ     <= '0;
         timerQ       <= '0;
         doneQ        <= 1'b0;
         ssLowQ       <= 1'b0;
         busyQ        <= 1'b0;
         frameDoneQ   <= 1'b0;
         errQ         <= 1'b0;
         sampleStartQ <= 1'b0;
         fbWeQ        <= 1'b0;
         fbAddrQ      <= '0;
         fbDataQ      <= '0;
      end else begin
         stateQ       <= stateD;
         pixelXQ      <= pixelXD;
         pixelYQ      <= pixelYD;
         planeLoQ     <= planeLoD;
         planeHiQ     <= planeHiD;
         timerQ       <= timerD;
         doneQ        <= SampleDone;
         ssLowQ       <= ~sampleStartQ;
         busyQ        <= busyD;
         frameDoneQ   <= frameDoneD;
         errQ         <= errD;
         sampleStartQ <= sampleStartD;
         fbWeQ        <= fbWeD;
         fbAddrQ      <= fbAddrD;
         fbDataQ      <= fbDataD;
      end
   end

   assign FrameBusy        = busyQ;
   assign FrameDone        = frameDoneQ;
   assign SampleTimeoutErr = errQ;
   assign SampleStart      = sampleStartQ;
   assign PixelX           = pixelXQ;
   assign PixelY           = pixelYQ;
   assign FbWriteEn        = fbWeQ;
   assign FbWriteAddr      = fbAddrQ;
   assign FbWriteData      = fbDataQ;

endmodule
